// File: rtl/batcharger_adcseq.sv
// Round-robin ADC sequencer for battery-charger voltage/current/temperature monitoring.
// Selects a channel, lets the mux settle, pulses a conversion start, then stores the result.
module batcharger_adcseq #(
  parameter int unsigned SETTLE  = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       vmonen,
  input  logic       imonen,
  input  logic       tmonen,
  output logic [1:0] adc_sel,
  output logic       adc_start,
  input  logic       adc_done,
  input  logic [7:0] adc_data,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] tbat,
  output logic       vtok,
  output logic       adc_err
);

  typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_SETTLE, ST_START, ST_WAIT} state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  // WAIT begins the cycle after adc_start, so the last allowed WAIT cycle is TIMEOUT-2.
  localparam logic [7:0] WAIT_LAST   = 8'(TIMEOUT - 2);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic       start_q, start_d;
  logic       err_q, err_d;
  logic       vtok_q, vtok_d;

  logic [2:0]  mon;
  logic [2:0]  load;
  logic        clr_valid;
  logic [2:0]  valid_all;
  logic [2:0]  valid_nx;
  logic [23:0] res_all;
  logic [1:0]  cand_ch [3];
  logic [2:0]  cand_ok;

  assign mon = {tmonen, imonen, vmonen};

  // Candidate gi is the channel gi steps after the round-robin pointer.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cand
    logic [2:0] sum;
    assign sum         = {1'b0, ptr_q} + 3'(gi);
    assign cand_ch[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    assign cand_ok[gi] = mon[cand_ch[gi]];
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    err_d     = err_q;
    load      = '0;
    clr_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|mon) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (cand_ok[0]) begin
          sel_d   = cand_ch[0];
          state_d = ST_SETTLE;
        end else if (cand_ok[1]) begin
          sel_d   = cand_ch[1];
          state_d = ST_SETTLE;
        end else if (cand_ok[2]) begin
          sel_d   = cand_ch[2];
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q >= SETTLE_LAST) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (adc_done) begin
          load[sel_q] = 1'b1;
          ptr_d       = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
          state_d     = ST_SELECT;
        end else if (cnt_q >= WAIT_LAST) begin
          err_d     = 1'b1;
          clr_valid = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Disabling drops any conversion in flight, including a completion in this cycle.
    if (!en) begin
      state_d   = ST_IDLE;
      ptr_d     = ptr_q;
      load      = '0;
      clr_valid = 1'b1;
    end
    if (state_d != state_q) cnt_d = 8'd0;
    else if (cnt_q == 8'hFF) cnt_d = cnt_q;
    else cnt_d = cnt_q + 8'd1;
    start_d = (state_d == ST_START);
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    logic [7:0] res_q, res_d;
    logic       valid_q, valid_d;

    always_comb begin
      res_d   = res_q;
      valid_d = valid_q;
      if (clr_valid) begin
        valid_d = 1'b0;
      end else if (load[gi]) begin
        res_d   = adc_data;
        valid_d = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        res_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        res_q   <= res_d;
        valid_q <= valid_d;
      end
    end

    assign res_all[gi*8 +: 8] = res_q;
    assign valid_all[gi]      = valid_q;
    assign valid_nx[gi]       = valid_d;
  end

  // Rises one cycle after both V and T are valid; falls together with the flags.
  assign vtok_d = valid_all[0] & valid_all[2] & valid_nx[0] & valid_nx[2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      vtok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      start_q <= start_d;
      err_q   <= err_d;
      vtok_q  <= vtok_d;
    end
  end

  assign adc_sel   = sel_q;
  assign adc_start = start_q;
  assign vbat      = res_all[7:0];
  assign ibat      = res_all[15:8];
  assign tbat      = res_all[23:16];
  assign vtok      = vtok_q;
  assign adc_err   = err_q;

endmodule

// File: tb/tb_batcharger_adcseq.sv
// Scoreboard bench for batcharger_adcseq: expected selects/results are queued by the
// stimulus and popped by a monitor whenever the DUT pulses adc_start or sees adc_done.
module tb_batcharger_adcseq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       vmonen = 1'b0;
  logic       imonen = 1'b0;
  logic       tmonen = 1'b0;
  logic       adc_done = 1'b0;
  logic [7:0] adc_data = 8'h00;
  logic [1:0] adc_sel;
  logic       adc_start;
  logic [7:0] vbat, ibat, tbat;
  logic       vtok, adc_err;

  batcharger_adcseq #(.SETTLE(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .en(en),
    .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
    .adc_sel(adc_sel), .adc_start(adc_start),
    .adc_done(adc_done), .adc_data(adc_data),
    .vbat(vbat), .ibat(ibat), .tbat(tbat),
    .vtok(vtok), .adc_err(adc_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [1:0] sel; int stable;} sel_exp_t;
  typedef struct {logic [7:0] v; logic [7:0] i; logic [7:0] t;} res_exp_t;
  sel_exp_t sel_q[$];
  res_exp_t res_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_sel(input logic [1:0] s, input int stable);
    sel_exp_t e;
    e.sel = s;
    e.stable = stable;
    sel_q.push_back(e);
  endtask

  task automatic push_res(input logic [7:0] v, input logic [7:0] i, input logic [7:0] t);
    res_exp_t e;
    e.v = v;
    e.i = i;
    e.t = t;
    res_q.push_back(e);
  endtask

  // Monitor: tracks how long adc_sel has been stable and checks every start and every result.
  logic       done_prev = 1'b0;
  logic [1:0] prev_sel = 2'd0;
  int         run = 0;
  int         n_starts = 0;
  always @(negedge clk) begin
    sel_exp_t se;
    res_exp_t re;
    if (adc_sel == prev_sel) run++;
    else run = 1;
    prev_sel = adc_sel;
    if (adc_start) begin
      n_starts++;
      if (sel_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_start: got adc_start=1 sel=%0d, required no start", adc_sel);
      end else begin
        se = sel_q.pop_front();
        $display("start  t=%0t sel=%0d (expect %0d) stable=%0d", $time, adc_sel, se.sel, run - 1);
        check("adc_sel", 32'(adc_sel), 32'(se.sel));
        if (se.stable >= 0) check("settle_len", 32'(run - 1), 32'(se.stable));
        else check("settle_min", 32'(run - 1 >= 4), 32'd1);
      end
    end
    if (done_prev) begin
      if (res_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done with no expected result, required none");
      end else begin
        re = res_q.pop_front();
        $display("result t=%0t v=%02h i=%02h t=%02h (expect %02h %02h %02h)",
                 $time, vbat, ibat, tbat, re.v, re.i, re.t);
        check("vbat", 32'(vbat), 32'(re.v));
        check("ibat", 32'(ibat), 32'(re.i));
        check("tbat", 32'(tbat), 32'(re.t));
      end
    end
    done_prev = adc_done;
  end

  task automatic wait_start(input int bound);
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (adc_start) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_start: got no adc_start in %0d cycles, required one", bound);
  endtask

  // Assert adc_done k edges from now (called from the START-cycle negedge gives delay k).
  task automatic pulse_done(input int k, input logic [7:0] d, input logic with_rst);
    repeat (k) @(posedge clk);
    #1;
    adc_done = 1'b1;
    adc_data = d;
    if (with_rst) rst = 1'b1;
    @(posedge clk);
    #1;
    adc_done = 1'b0;
    adc_data = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b0; vmonen = 1'b0; imonen = 1'b0; tmonen = 1'b0; adc_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("sel_queue_drained", 32'(sel_q.size()), 32'd0);
    check("res_queue_drained", 32'(res_q.size()), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n0;
    logic [7:0] d2 [6];
    logic [7:0] ev, ei, et;

    // Reset held with en and monitors active: reset must win.
    en = 1'b1; vmonen = 1'b1; tmonen = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("rst_adc_sel", 32'(adc_sel), 32'd0);
    check("rst_adc_start", 32'(adc_start), 32'd0);
    check("rst_vbat", 32'(vbat), 32'd0);
    check("rst_ibat", 32'(ibat), 32'd0);
    check("rst_tbat", 32'(tbat), 32'd0);
    check("rst_vtok", 32'(vtok), 32'd0);
    check("rst_adc_err", 32'(adc_err), 32'd0);

    // V and T, done delay 3: sel 0 then 2, vtok one cycle after tbat.
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1; vmonen = 1'b1; imonen = 1'b0; tmonen = 1'b1;
    c0 = cyc;
    push_sel(2'd0, -1); push_sel(2'd2, 4);
    push_res(8'hB4, 8'h00, 8'h00); push_res(8'hB4, 8'h00, 8'h66);
    wait_start(20);
    pulse_done(3, 8'hB4, 1'b0);
    check("first_update_latency", 32'(cyc - c0 - 1), 32'(1 + 4 + 1 + 3));
    check("vbat_at_latency", 32'(vbat), 32'hB4);
    wait_start(20);
    pulse_done(3, 8'h66, 1'b0);
    check("tbat_update", 32'(tbat), 32'h66);
    check("vtok_not_yet", 32'(vtok), 32'd0);
    @(posedge clk);
    #1;
    check("vtok_rises", 32'(vtok), 32'd1);
    do_reset();

    // All three channels: 0,1,2,0,1,2 with four settle cycles each.
    en = 1'b1; vmonen = 1'b1; imonen = 1'b1; tmonen = 1'b1;
    d2 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    ev = 8'h00; ei = 8'h00; et = 8'h00;
    push_sel(2'd0, -1);
    for (int i = 0; i < 6; i++) begin
      if (i % 3 == 0) ev = d2[i];
      else if (i % 3 == 1) ei = d2[i];
      else et = d2[i];
      push_res(ev, ei, et);
      if (i > 0) push_sel(2'(i % 3), 4);
    end
    for (int i = 0; i < 6; i++) begin
      wait_start(20);
      pulse_done(2, d2[i], 1'b0);
    end
    do_reset();

    // Timeout: V/T converted, then the next V conversion never completes.
    en = 1'b1; vmonen = 1'b1; tmonen = 1'b1;
    push_sel(2'd0, -1); push_sel(2'd2, 4); push_sel(2'd0, 4); push_sel(2'd0, -1);
    push_res(8'h10, 8'h00, 8'h00); push_res(8'h10, 8'h00, 8'h20);
    wait_start(20);
    pulse_done(1, 8'h10, 1'b0);
    wait_start(20);
    pulse_done(1, 8'h20, 1'b0);
    @(posedge clk);
    #1;
    check("vtok_before_timeout", 32'(vtok), 32'd1);
    wait_start(20);
    repeat (63) @(posedge clk);
    @(negedge clk);
    check("err_not_early", 32'(adc_err), 32'd0);
    @(negedge clk);
    check("err_at_timeout", 32'(adc_err), 32'd1);
    check("vtok_at_timeout", 32'(vtok), 32'd0);
    wait_start(20);
    check("err_sticky", 32'(adc_err), 32'd1);
    do_reset();
    check("err_cleared_by_rst", 32'(adc_err), 32'd0);

    // en dropped during WAIT, then a done with 0xFF arrives.
    en = 1'b1; vmonen = 1'b1; tmonen = 1'b1;
    push_sel(2'd0, -1); push_sel(2'd2, 4); push_sel(2'd0, 4);
    push_res(8'h5A, 8'h00, 8'h00); push_res(8'h5A, 8'h00, 8'hA5); push_res(8'h5A, 8'h00, 8'hA5);
    wait_start(20);
    pulse_done(2, 8'h5A, 1'b0);
    wait_start(20);
    pulse_done(2, 8'hA5, 1'b0);
    wait_start(20);
    @(posedge clk);
    #1;
    en = 1'b0;
    pulse_done(1, 8'hFF, 1'b0);
    check("vbat_held_when_disabled", 32'(vbat), 32'h5A);
    check("vtok_cleared_by_en", 32'(vtok), 32'd0);
    n0 = n_starts;
    repeat (20) @(negedge clk);
    check("no_start_while_disabled", 32'(n_starts - n0), 32'd0);
    @(posedge clk);
    #1;
    push_sel(2'd0, -1);
    en = 1'b1;
    wait_start(20);
    do_reset();

    // vmonen dropped mid-WAIT: result still stored, V then skipped, vtok held.
    en = 1'b1; vmonen = 1'b1; tmonen = 1'b1;
    push_sel(2'd0, -1); push_sel(2'd2, 4); push_sel(2'd0, 4); push_sel(2'd2, 4); push_sel(2'd2, -1);
    push_res(8'h01, 8'h00, 8'h00); push_res(8'h01, 8'h00, 8'h02);
    push_res(8'h77, 8'h00, 8'h02); push_res(8'h77, 8'h00, 8'h03);
    wait_start(20);
    pulse_done(2, 8'h01, 1'b0);
    wait_start(20);
    pulse_done(2, 8'h02, 1'b0);
    @(posedge clk);
    #1;
    check("vtok_before_drop", 32'(vtok), 32'd1);
    wait_start(20);
    @(posedge clk);
    #1;
    vmonen = 1'b0;
    pulse_done(1, 8'h77, 1'b0);
    wait_start(20);
    pulse_done(2, 8'h03, 1'b0);
    wait_start(20);
    check("vtok_persists", 32'(vtok), 32'd1);
    do_reset();

    // rst in the same cycle as adc_done: everything zero, result discarded.
    en = 1'b1; tmonen = 1'b1;
    push_sel(2'd2, 4); push_sel(2'd2, -1);
    push_res(8'h00, 8'h00, 8'h3C); push_res(8'h00, 8'h00, 8'h00);
    wait_start(20);
    pulse_done(2, 8'h3C, 1'b0);
    wait_start(20);
    pulse_done(2, 8'h99, 1'b1);
    check("rstdone_tbat", 32'(tbat), 32'd0);
    check("rstdone_adc_sel", 32'(adc_sel), 32'd0);
    check("rstdone_adc_start", 32'(adc_start), 32'd0);
    check("rstdone_vtok", 32'(vtok), 32'd0);
    check("rstdone_adc_err", 32'(adc_err), 32'd0);
    do_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/batcharger_adcseq.md
BATCHARGER_ADCSEQ -- requirements
Module: batcharger_adcseq

Interface
REQ-001 SHALL have parameter SETTLE, default 4: mux settling cycles before each conversion start (legal range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 64: maximum cycles allowed from adc_start to adc_done (legal range 2..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: sequencer enable.
REQ-006 SHALL have ports vmonen, imonen and tmonen, each input, 1 bit: request monitoring of voltage, current and temperature respectively.
REQ-007 SHALL have port adc_sel, output, 2 bits: ADC input mux select, registered (0=voltage, 1=current, 2=temperature, 3 never driven).
REQ-008 SHALL have port adc_start, output, 1 bit: one-cycle conversion start pulse, registered.
REQ-009 SHALL have port adc_done, input, 1 bit: conversion-complete pulse; adc_data is valid in the same cycle.
REQ-010 SHALL have port adc_data, input, 8 bits: conversion result.
REQ-011 SHALL have ports vbat, ibat and tbat, each output, 8 bits: last stored voltage, current and temperature results.
REQ-012 SHALL have port vtok, output, 1 bit: voltage and temperature results are valid.
REQ-013 SHALL have port adc_err, output, 1 bit: sticky conversion-timeout flag.

Function
REQ-014 SHALL implement an FSM with states IDLE, SELECT, SETTLE, START and WAIT.
REQ-015 In IDLE with en=1 and any monitor enable high, the FSM SHALL move to SELECT; otherwise it SHALL remain in IDLE.
REQ-016 SELECT SHALL pick the next enabled channel in round-robin order V->I->T->V, starting after the last converted channel, skipping disabled channels, and register it onto adc_sel.
REQ-017 After reset, the first channel considered by SELECT SHALL be V.
REQ-018 If no enable is high in SELECT, the FSM SHALL return to IDLE without changing adc_sel.
REQ-019 SETTLE SHALL last exactly SETTLE cycles and then move to START.
REQ-020 START SHALL assert adc_start for exactly one cycle and then move to WAIT.
REQ-021 In WAIT, on the edge at which adc_done=1: the selected result register SHALL load adc_data, its valid flag SHALL set, and the FSM SHALL move to SELECT.
REQ-022 Per-channel latency from SELECT entry to result update SHALL be 1 (SELECT) + SETTLE + 1 (START) + N cycles, where N >= 1 is the adc_done delay.
REQ-023 adc_done SHALL be ignored in every state except WAIT.
REQ-024 If adc_done is not received within TIMEOUT cycles of the adc_start cycle, the FSM SHALL set adc_err, clear all valid flags, and return to IDLE.
REQ-025 adc_err SHALL clear only on rst.
REQ-026 If a channel's monitor enable drops during SETTLE, START or WAIT, the conversion SHALL still complete and its result SHALL be stored.
REQ-027 en=0 SHALL override every state: on the next edge the FSM SHALL go to IDLE, adc_start SHALL be 0, and all valid flags SHALL clear; result registers SHALL hold their values.
REQ-028 vtok SHALL equal (V valid AND T valid), registered; valid flags SHALL persist while the corresponding monitor enable is low.
REQ-029 The ibat valid flag SHALL be internal only and SHALL NOT affect vtok.
REQ-030 The SETTLE and TIMEOUT counters SHALL be 8 bits wide, SHALL saturate rather than wrap, and SHALL be cleared on every state entry.

Reset
REQ-031 While rst=1, the FSM SHALL be in IDLE and all outputs SHALL be 0: adc_sel=0, adc_start=0, vbat=ibat=tbat=8'h00, vtok=0, adc_err=0.
REQ-032 While rst=1, the round-robin pointer SHALL be V and all valid flags SHALL be clear.
REQ-033 rst SHALL have priority over en and over adc_done, including reset asserted mid-conversion.

Verification
REQ-034 Bench SHALL cover: en=1, vmonen=tmonen=1, imonen=0, ADC done delay 3 returning 0xB4 then 0x66 -> adc_sel sequence 0,2; vbat=0xB4, tbat=0x66; vtok rises 1 cycle after the tbat update; first update occurs 1+4+1+3 cycles after en.
REQ-035 Bench SHALL cover: all three enables high -> adc_sel repeats 0,1,2,0,1,2 and each adc_start is preceded by exactly 4 cycles of stable adc_sel.
REQ-036 Bench SHALL cover: adc_done never asserted -> 64 cycles after adc_start, adc_err=1 and vtok=0, then the FSM retries from IDLE; adc_err stays 1 until rst.
REQ-037 Bench SHALL cover: en dropped during WAIT, then adc_done pulsed with 0xFF -> vbat unchanged, vtok=0, no further adc_start until en returns.
REQ-038 Bench SHALL cover: vmonen dropped mid-WAIT -> vbat still loads adc_data; the next adc_sel skips V; vtok stays 1.
REQ-039 Bench SHALL cover: rst asserted in the same cycle as adc_done=1 -> all outputs 0 on that edge and the result is discarded.
